// File: rtl/rvm_ifu_pkg.sv
// Shared types and constants for the rvm instruction fetch unit.
package rvm_ifu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } ifu_state_e;

    // Delivered instruction payload: word plus the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata;
    } ifu_instr_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rvm_ifu.sv
// Instruction fetch unit: single-outstanding word fetch with deferred redirects.
module rvm_ifu
    import rvm_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            fetch_en,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_load_addr,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_rdata,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_misaligned,
    output logic            busy
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            instr_valid_q, instr_valid_d;
    ifu_instr_t      instr_q, instr_d;
    logic            misaligned_q, misaligned_d;
    logic            busy_q, busy_d;

    logic [XLEN-1:0] fetch_addr_c;
    logic            redir_c;
    logic [XLEN-1:0] redir_addr_c;

    // A same-cycle pc_load wins over the held PC / pending redirect
    assign fetch_addr_c = pc_load ? pc_load_addr : pc_q;
    assign redir_c      = pc_load | pend_q;
    assign redir_addr_c = pc_load ? pc_load_addr : pend_addr_q;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (fetch_en && is_word_aligned(fetch_addr_c)) state_d = ST_REQ;
            ST_REQ:  if (mem_gnt)    state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        misaligned_d  = 1'b0;
        busy_d        = (state_d != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                pc_d = fetch_addr_c;
                if (fetch_en) begin
                    if (is_word_aligned(fetch_addr_c)) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_addr_c;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (pc_load) begin
                    pend_d      = 1'b1;
                    pend_addr_d = pc_load_addr;
                end
                if (mem_gnt) mem_req_d = 1'b0;
            end
            ST_WAIT: begin
                if (pc_load) begin
                    pend_d      = 1'b1;
                    pend_addr_d = pc_load_addr;
                end
                if (mem_rvalid) begin
                    if (redir_c) begin
                        // Response belongs to the abandoned stream: drop it
                        pc_d   = redir_addr_c;
                        pend_d = 1'b0;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_d.rdata = mem_rdata;
                        instr_d.pc    = pc_q;
                        pc_d          = pc_q + PC_STEP;
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
                pend_d    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q          <= RESET_PC;
            pend_q        <= 1'b0;
            pend_addr_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            misaligned_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            misaligned_q  <= misaligned_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_addr         = mem_addr_q;
    assign instr_valid      = instr_valid_q;
    assign instr_rdata      = instr_q.rdata;
    assign instr_pc         = instr_q.pc;
    assign fetch_misaligned = misaligned_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_rvm_ifu.sv
// Self-checking bench for rvm_ifu: directed scenarios then randomized traffic.
module tb_rvm_ifu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fetch_en = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: what has been asked of memory and what is owed
    logic [31:0] m_pc;
    bit          m_outstanding;
    bit          m_granted;
    bit          m_redirect;
    logic [31:0] m_redirect_addr;
    logic        e_req, e_iv, e_mis, e_busy;
    logic [31:0] e_addr, e_rdata, e_ipc;

    always #5 clk = ~clk;

    rvm_ifu dut (
        .clk              (clk),
        .resetn           (resetn),
        .fetch_en         (fetch_en),
        .pc_load          (pc_load),
        .pc_load_addr     (pc_load_addr),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .instr_valid      (instr_valid),
        .instr_rdata      (instr_rdata),
        .instr_pc         (instr_pc),
        .fetch_misaligned (fetch_misaligned),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":mem_req"},          32'(mem_req),          32'(e_req));
        chk({ctx, ":mem_addr"},         mem_addr,              e_addr);
        chk({ctx, ":instr_valid"},      32'(instr_valid),      32'(e_iv));
        chk({ctx, ":instr_rdata"},      instr_rdata,           e_rdata);
        chk({ctx, ":instr_pc"},         instr_pc,              e_ipc);
        chk({ctx, ":fetch_misaligned"}, 32'(fetch_misaligned), 32'(e_mis));
        chk({ctx, ":busy"},             32'(busy),             32'(e_busy));
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_outstanding = 0; m_granted = 0;
        m_redirect = 0; m_redirect_addr = 32'h0;
        e_req = 0; e_addr = 32'h0; e_iv = 0; e_rdata = 32'h0;
        e_ipc = 32'h0; e_mis = 0; e_busy = 0;
    endtask

    // Advance the reference by one clock using the inputs seen at the edge
    task automatic model_edge(input bit fe, input bit pl, input logic [31:0] pla,
                              input bit gnt, input bit rv, input logic [31:0] rd);
        logic [31:0] target;
        e_iv  = 0;
        e_mis = 0;
        if (!m_outstanding) begin
            target = pl ? pla : m_pc;
            m_pc   = target;
            if (fe) begin
                if (target[1:0] != 2'b00) begin
                    e_mis = 1;
                end else begin
                    m_outstanding = 1;
                    m_granted     = 0;
                    e_req         = 1;
                    e_addr        = target;
                end
            end
        end else begin
            if (pl) begin
                m_redirect      = 1;
                m_redirect_addr = pla;
            end
            if (!m_granted) begin
                if (gnt) begin
                    m_granted = 1;
                    e_req     = 0;
                end
            end else if (rv) begin
                m_outstanding = 0;
                if (m_redirect) begin
                    m_pc       = m_redirect_addr;
                    m_redirect = 0;
                end else begin
                    e_iv    = 1;
                    e_rdata = rd;
                    e_ipc   = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
            end
        end
        e_busy = m_outstanding;
    endtask

    task automatic step(input string ctx, input bit fe, input bit pl, input logic [31:0] pla,
                        input bit gnt, input bit rv, input logic [31:0] rd);
        fetch_en     = fe;
        pc_load      = pl;
        pc_load_addr = pla;
        mem_gnt      = gnt;
        mem_rvalid   = rv;
        mem_rdata    = rd;
        @(posedge clk);
        model_edge(fe, pl, pla, gnt, rv, rd);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        fetch_en = 0; pc_load = 0; mem_gnt = 0; mem_rvalid = 0;
        resetn = 1'b0;
        model_reset();
        #2;
        check_all(ctx);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        bit          fe, pl, gnt, rv;
        logic [31:0] pla;
        model_reset();
        #3;
        do_reset("reset");

        // Basic fetch with earliest grant and response
        step("basic_issue", 1, 0, 32'h0, 0, 0, 32'h0);
        chk("basic_addr0", mem_addr, 32'h0);
        step("basic_gnt",   0, 0, 32'h0, 1, 0, 32'h0);
        step("basic_rsp",   0, 0, 32'h0, 0, 1, 32'h0000_0013);
        chk("basic_latency_iv", 32'(instr_valid), 32'd1);
        step("basic_hold",  0, 0, 32'h0, 0, 0, 32'hdead_beef);

        // Grant held off four cycles; stray rvalid during REQ must be ignored
        step("stall_issue", 1, 0, 32'h0, 0, 0, 32'h0);
        chk("stall_addr4", mem_addr, 32'h4);
        for (int i = 0; i < 4; i++) step("stall_wait", 0, 0, 32'h0, 0, (i == 1), 32'h1111_1111);
        step("stall_gnt", 0, 0, 32'h0, 1, 0, 32'h0);
        step("stall_rsp", 0, 0, 32'h0, 0, 1, 32'h2222_2222);
        step("stall_idle", 0, 0, 32'h0, 0, 0, 32'h0);

        // Redirect during WAIT discards the response
        step("redir_issue", 1, 0, 32'h0, 0, 0, 32'h0);
        step("redir_gnt",   0, 0, 32'h0, 1, 0, 32'h0);
        step("redir_load",  0, 1, 32'h100, 0, 0, 32'h0);
        chk("redir_addr_kept", mem_addr, 32'h8);
        step("redir_drop",  0, 0, 32'h0, 0, 1, 32'h3333_3333);
        step("redir_next",  1, 0, 32'h0, 0, 0, 32'h0);
        chk("redir_addr100", mem_addr, 32'h100);
        // Last redirect wins: one in REQ, another in WAIT
        step("lw_req_load", 0, 1, 32'h200, 0, 0, 32'h0);
        step("lw_gnt",      0, 0, 32'h0, 1, 0, 32'h0);
        step("lw_wait_load",0, 1, 32'h300, 0, 0, 32'h0);
        step("lw_drop",     0, 0, 32'h0, 0, 1, 32'h4444_4444);
        step("lw_next",     1, 0, 32'h0, 0, 0, 32'h0);
        chk("lw_addr300", mem_addr, 32'h300);
        step("lw_gnt2",     0, 0, 32'h0, 1, 0, 32'h0);
        step("lw_rsp2",     0, 0, 32'h0, 0, 1, 32'h5555_5555);

        // Misaligned fetch, separate load then fetch, and combined
        step("mis_load",    0, 1, 32'h102, 0, 0, 32'h0);
        step("mis_fetch",   1, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_pulse", 32'(fetch_misaligned), 32'd1);
        step("mis_clear",   0, 0, 32'h0, 0, 0, 32'h0);
        step("mis_both",    1, 1, 32'h105, 0, 0, 32'h0);
        step("prio_both",   1, 1, 32'h40, 0, 0, 32'h0);
        chk("prio_addr40", mem_addr, 32'h40);
        step("prio_gnt",    0, 0, 32'h0, 1, 0, 32'h0);
        step("prio_rsp",    0, 0, 32'h0, 0, 1, 32'h6666_6666);

        // PC wrap
        step("wrap_issue",  1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        step("wrap_gnt",    0, 0, 32'h0, 1, 0, 32'h0);
        step("wrap_rsp",    0, 0, 32'h0, 0, 1, 32'h7777_7777);
        step("wrap_next",   1, 0, 32'h0, 0, 0, 32'h0);
        chk("wrap_addr0", mem_addr, 32'h0);
        step("wrap_gnt2",   0, 0, 32'h0, 1, 0, 32'h0);
        step("wrap_rsp2",   0, 0, 32'h0, 0, 1, 32'h8888_8888);

        // Reset during WAIT, then a stale response
        step("rst_issue",   1, 1, 32'h80, 0, 0, 32'h0);
        step("rst_gnt",     0, 0, 32'h0, 1, 0, 32'h0);
        do_reset("rst_mid");
        step("rst_stale",   0, 0, 32'h0, 0, 1, 32'h9999_9999);
        step("rst_next",    1, 0, 32'h0, 0, 0, 32'h0);
        chk("rst_addr_resetpc", mem_addr, 32'h0);
        step("rst_gnt2",    0, 0, 32'h0, 1, 0, 32'h0);
        step("rst_rsp2",    0, 0, 32'h0, 0, 1, 32'haaaa_aaaa);

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            if (i % 250 == 125) do_reset("rand_reset");
            fe  = ($urandom % 2) == 0;
            pl  = ($urandom % 8) == 0;
            pla = $urandom;
            if (($urandom % 8) != 0) pla[1:0] = 2'b00;
            gnt = ($urandom % 3) == 0;
            rv  = ($urandom % 3) == 0;
            step("rand", fe, pl, pla, gnt, rv, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
